// File: rtl/axi_to_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_to_mem_pkg
// Description : Shared burst encodings, FSM states and WRAP helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_to_mem_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   function automatic logic wrap_len_legal(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

   // Largest legal container is 16 beats of 128 bytes, so 12 bits always suffice.
   function automatic logic [11:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
      logic [11:0] container;
      container = ({4'b0000, len} + 12'd1) << size;
      return container - 12'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_beat_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_beat_next_addr
// Description : Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_beat_next_addr
   import axi_to_mem_pkg::*;
#(
   parameter int unsigned AddrWidth = 32
) (
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [2:0]           size_i,
   input  logic [7:0]           len_i,
   input  logic [1:0]           burst_i,
   output logic [AddrWidth-1:0] next_addr_o
);

   logic [AddrWidth-1:0] incr;
   logic [AddrWidth-1:0] aligned;
   logic [AddrWidth-1:0] wmask;

   always_comb begin
      incr        = AddrWidth'(1) << size_i;
      aligned     = addr_i & ~(incr - AddrWidth'(1));
      wmask       = AddrWidth'(wrap_mask(len_i, size_i));
      next_addr_o = aligned + incr;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_WRAP: begin
            // An illegal WRAP length falls through to the INCR result above.
            if (wrap_len_legal(len_i)) begin
               next_addr_o = (addr_i & ~wmask) | ((addr_i + incr) & wmask);
            end
         end
         default: next_addr_o = aligned + incr;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/axi_burst_beat_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_beat_gen
// Description : Expands an accepted AXI AW/AR burst into per-beat requests.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_beat_gen
   import axi_to_mem_pkg::*;
#(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned IdWidth   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 ax_valid_i,
   output logic                 ax_ready_o,
   input  logic [AddrWidth-1:0] ax_addr_i,
   input  logic [7:0]           ax_len_i,
   input  logic [2:0]           ax_size_i,
   input  logic [1:0]           ax_burst_i,
   input  logic [IdWidth-1:0]   ax_id_i,
   output logic                 beat_valid_o,
   input  logic                 beat_ready_i,
   output logic [AddrWidth-1:0] beat_addr_o,
   output logic [2:0]           beat_size_o,
   output logic [IdWidth-1:0]   beat_id_o,
   output logic                 beat_last_o,
   output logic                 busy_o
);

   localparam logic [2:0] c_max_size = 3'($clog2(DataWidth / 8));

   state_e               state_q, state_d;
   logic [7:0]           cnt_q, cnt_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [2:0]           size_q, size_d;
   logic [7:0]           len_q, len_d;
   logic [1:0]           burst_q, burst_d;
   logic [IdWidth-1:0]   id_q, id_d;
   logic                 last_q, last_d;

   logic [2:0]           eff_size;
   logic [AddrWidth-1:0] next_addr;
   logic                 ax_hs;
   logic                 beat_hs;

   axi_beat_next_addr #(
      .AddrWidth (AddrWidth)
   ) u_next_addr (
      .addr_i      (addr_q),
      .size_i      (size_q),
      .len_i       (len_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   // Chaining: the final beat's handshake may accept the next burst in the same cycle.
   assign ax_ready_o   = (state_q == IDLE) ? 1'b1 : (last_q & beat_ready_i);
   assign beat_valid_o = (state_q == BURST);
   assign busy_o       = (state_q == BURST);
   assign beat_addr_o  = addr_q;
   assign beat_size_o  = size_q;
   assign beat_id_o    = id_q;
   assign beat_last_o  = last_q;

   assign ax_hs   = ax_valid_i & ax_ready_o;
   assign beat_hs = beat_valid_o & beat_ready_i;
   assign eff_size = (ax_size_i > c_max_size) ? c_max_size : ax_size_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      len_d   = len_q;
      burst_d = burst_q;
      id_d    = id_q;
      last_d  = last_q;
      if (ax_hs) begin
         state_d = BURST;
         cnt_d   = ax_len_i;
         addr_d  = ax_addr_i;
         size_d  = eff_size;
         len_d   = ax_len_i;
         burst_d = ax_burst_i;
         id_d    = ax_id_i;
         last_d  = (ax_len_i == 8'd0);
      end else if (beat_hs) begin
         if (cnt_q == 8'd0) begin
            state_d = IDLE;
            last_d  = 1'b0;
         end else begin
            cnt_d  = cnt_q - 8'd1;
            addr_d = next_addr;
            last_d = (cnt_q == 8'd1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         addr_q  <= '0;
         size_q  <= 3'd0;
         len_q   <= 8'd0;
         burst_q <= BURST_FIXED;
         id_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_beat_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_beat_gen
// Description : Scoreboard bench for the burst-to-beat expander.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_beat_gen;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  id;
      logic        last;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        ax_valid_i;
   logic        ax_ready_o;
   logic [31:0] ax_addr_i;
   logic [7:0]  ax_len_i;
   logic [2:0]  ax_size_i;
   logic [1:0]  ax_burst_i;
   logic [3:0]  ax_id_i;
   logic        beat_valid_o;
   logic        beat_ready_i = 1'b1;
   logic [31:0] beat_addr_o;
   logic [2:0]  beat_size_o;
   logic [3:0]  beat_id_o;
   logic        beat_last_o;
   logic        busy_o;

   logic        toggle_en = 1'b0;
   beat_t       sb_q[$];
   beat_t       stall_snap;
   logic        stall_seen = 1'b0;
   int          n_pass = 0;
   int          n_total = 0;

   axi_burst_beat_gen #(
      .AddrWidth (32),
      .DataWidth (64),
      .IdWidth   (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .ax_valid_i   (ax_valid_i),
      .ax_ready_o   (ax_ready_o),
      .ax_addr_i    (ax_addr_i),
      .ax_len_i     (ax_len_i),
      .ax_size_i    (ax_size_i),
      .ax_burst_i   (ax_burst_i),
      .ax_id_i      (ax_id_i),
      .beat_valid_o (beat_valid_o),
      .beat_ready_i (beat_ready_i),
      .beat_addr_o  (beat_addr_o),
      .beat_size_o  (beat_size_o),
      .beat_id_o    (beat_id_o),
      .beat_last_o  (beat_last_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      #1;
      if (toggle_en) beat_ready_i = ~beat_ready_i;
      else           beat_ready_i = 1'b1;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] id, input logic last);
      beat_t b;
      b.addr = addr; b.size = size; b.id = id; b.last = last;
      sb_q.push_back(b);
   endtask

   // Pop and compare on every beat handshake; also verify outputs hold while stalled.
   always @(negedge clk_i) begin
      beat_t e;
      if (!rst_ni) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check_eq("stall_valid", beat_valid_o, 1'b1);
            check_eq("stall_addr", beat_addr_o, stall_snap.addr);
            check_eq("stall_id",   beat_id_o,   stall_snap.id);
            check_eq("stall_last", beat_last_o, stall_snap.last);
         end
         stall_seen = beat_valid_o && !beat_ready_i;
         stall_snap = '{beat_addr_o, beat_size_o, beat_id_o, beat_last_o};
         if (beat_valid_o && beat_ready_i) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_beat", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               check_eq("beat_addr", beat_addr_o, e.addr);
               check_eq("beat_size", beat_size_o, e.size);
               check_eq("beat_id",   beat_id_o,   e.id);
               check_eq("beat_last", beat_last_o, e.last);
            end
         end
      end
   end

   task automatic send_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input logic hold);
      logic ok;
      ok = 1'b0;
      ax_addr_i = addr; ax_len_i = len; ax_size_i = size;
      ax_burst_i = burst; ax_id_i = id; ax_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (ax_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("ax_hs_timeout", ax_ready_o, 1'b1);
      @(posedge clk_i);
      #1;
      if (!hold) ax_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_i);
         if (!busy_o && sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("drain_timeout", busy_o, 1'b0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni = 1'b0; ax_valid_i = 1'b0; ax_addr_i = '0; ax_len_i = '0;
      ax_size_i = '0; ax_burst_i = '0; ax_id_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      check_eq("rst_valid", beat_valid_o, 1'b0);
      check_eq("rst_last",  beat_last_o,  1'b0);
      check_eq("rst_busy",  busy_o,       1'b0);
      check_eq("rst_addr",  beat_addr_o,  32'h0);
      check_eq("rst_size",  beat_size_o,  3'd0);
      check_eq("rst_id",    beat_id_o,    4'd0);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check_eq("idle_ax_ready", ax_ready_o, 1'b1);

      // INCR aligned, one-cycle latency
      push_exp(32'h1000, 3'd3, 4'h3, 1'b0);
      push_exp(32'h1008, 3'd3, 4'h3, 1'b0);
      push_exp(32'h1010, 3'd3, 4'h3, 1'b0);
      push_exp(32'h1018, 3'd3, 4'h3, 1'b1);
      send_burst(32'h1000, 8'd3, 3'd3, 2'b01, 4'h3, 1'b0);
      check_eq("t1_latency_valid", beat_valid_o, 1'b1);
      check_eq("t1_latency_busy",  busy_o,       1'b1);
      wait_idle();

      // WRAP, unaligned INCR, illegal-length WRAP treated as INCR
      push_exp(32'h1018, 3'd3, 4'h1, 1'b0);
      push_exp(32'h1000, 3'd3, 4'h1, 1'b0);
      push_exp(32'h1008, 3'd3, 4'h1, 1'b0);
      push_exp(32'h1010, 3'd3, 4'h1, 1'b1);
      send_burst(32'h1018, 8'd3, 3'd3, 2'b10, 4'h1, 1'b0);
      wait_idle();
      push_exp(32'h1003, 3'd2, 4'h2, 1'b0);
      push_exp(32'h1004, 3'd2, 4'h2, 1'b1);
      send_burst(32'h1003, 8'd1, 3'd2, 2'b01, 4'h2, 1'b0);
      wait_idle();
      push_exp(32'h1018, 3'd3, 4'h4, 1'b0);
      push_exp(32'h1020, 3'd3, 4'h4, 1'b0);
      push_exp(32'h1028, 3'd3, 4'h4, 1'b1);
      send_burst(32'h1018, 8'd2, 3'd3, 2'b10, 4'h4, 1'b0);
      wait_idle();

      // FIXED with toggling ready
      toggle_en = 1'b1;
      push_exp(32'h2004, 3'd2, 4'h5, 1'b0);
      push_exp(32'h2004, 3'd2, 4'h5, 1'b0);
      push_exp(32'h2004, 3'd2, 4'h5, 1'b1);
      send_burst(32'h2004, 8'd2, 3'd2, 2'b00, 4'h5, 1'b0);
      wait_idle();
      toggle_en = 1'b0;
      @(posedge clk_i);
      #1;

      // Back-to-back chaining without bubble
      push_exp(32'h4000, 3'd3, 4'h1, 1'b1);
      push_exp(32'h5000, 3'd3, 4'h2, 1'b0);
      push_exp(32'h5008, 3'd3, 4'h2, 1'b1);
      send_burst(32'h4000, 8'd0, 3'd3, 2'b01, 4'h1, 1'b1);
      check_eq("t4_c1_valid", beat_valid_o, 1'b1);
      send_burst(32'h5000, 8'd1, 3'd3, 2'b01, 4'h2, 1'b0);
      check_eq("t4_c2_valid", beat_valid_o, 1'b1);
      check_eq("t4_c2_id",    beat_id_o,    4'h2);
      @(posedge clk_i);
      #1;
      check_eq("t4_c3_valid", beat_valid_o, 1'b1);
      check_eq("t4_c3_last",  beat_last_o,  1'b1);
      wait_idle();

      // Size clamp and address wrap-around
      push_exp(32'h0100, 3'd3, 4'h8, 1'b0);
      push_exp(32'h0108, 3'd3, 4'h8, 1'b1);
      send_burst(32'h0100, 8'd1, 3'd7, 2'b01, 4'h8, 1'b0);
      wait_idle();
      push_exp(32'hFFFF_FFF8, 3'd3, 4'h9, 1'b0);
      push_exp(32'h0000_0000, 3'd3, 4'h9, 1'b1);
      send_burst(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'h9, 1'b0);
      wait_idle();

      // Mid-burst reset
      push_exp(32'h3000, 3'd3, 4'h6, 1'b0);
      send_burst(32'h3000, 8'd7, 3'd3, 2'b01, 4'h6, 1'b0);
      @(posedge clk_i);
      #1;
      check_eq("t6_beat2_addr", beat_addr_o, 32'h3008);
      rst_ni = 1'b0;
      #1;
      check_eq("t6_rst_valid", beat_valid_o, 1'b0);
      check_eq("t6_rst_busy",  busy_o,       1'b0);
      check_eq("t6_rst_last",  beat_last_o,  1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      #1;
      check_eq("t6_post_ready", ax_ready_o,   1'b1);
      check_eq("t6_post_valid", beat_valid_o, 1'b0);
      push_exp(32'h6000, 3'd3, 4'h7, 1'b0);
      push_exp(32'h6008, 3'd3, 4'h7, 1'b1);
      send_burst(32'h6000, 8'd1, 3'd3, 2'b01, 4'h7, 1'b0);
      wait_idle();

      check_eq("sb_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
